// File: rtl/m31_sbox_array.sv
// m31_sbox_array: multi-lane pipelined M31 S-box (x^5 mod 2^31-1) for
// the Poseidon2 permutation datapath, built from m31_sqr/m31_mul cores.
//
// Optional feature macro: M31_SBOX_ARRAY_RC_EN. When it is defined there is
// an rc_i port and a registered modular round-constant add ahead of the
// S-box, and LATENCY is 16 instead of 15.
//
// Ports of m31_sbox_array:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   valid_i        beat present (no backpressure)
//   partial_i      1 = partial round (only lane 0 raised to x^5)
//   tag_i          opaque sideband, returned unchanged
//   data_i         LANES x 31-bit elements, lane k at [31k+30:31k]
//   rc_i           round constants, same packing (RC build only)
//   valid_o        result beat present
//   partial_o      delayed partial_i
//   tag_o          delayed tag_i
//   data_o         results, same packing as data_i
//
// Ports of m31_mul / m31_sqr: clk, rst_n (synchronous, active-low),
// operands a/b (or x), result y after 5 cycles, always canonical.

module m31_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:0] a,
    input  logic [30:0] b,
    output logic [30:0] y
);
    localparam logic [30:0] P = 31'h7FFFFFFF;

    logic [30:0] a_q;
    logic [30:0] b_q;
    logic [61:0] prod_q;
    logic [31:0] sum_q;
    logic [30:0] fold_q;
    logic [30:0] y_q;

    // 2^31 = 1 mod p, so the high half folds onto the low half. After one
    // carry fold the value is at most p, fixed by the final compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            sum_q  <= '0;
            fold_q <= '0;
            y_q    <= '0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= 62'(a_q) * 62'(b_q);
            sum_q  <= {1'b0, prod_q[30:0]} + {1'b0, prod_q[61:31]};
            fold_q <= sum_q[30:0] + {30'b0, sum_q[31]};
            y_q    <= (fold_q == P) ? '0 : fold_q;
        end
    end

    assign y = y_q;
endmodule

module m31_sqr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:0] x,
    output logic [30:0] y
);
    m31_mul u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (x),
        .b     (x),
        .y     (y)
    );
endmodule

module m31_sbox_array #(
    parameter int LANES = 16,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  partial_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [31*LANES-1:0]   data_i,
`ifdef M31_SBOX_ARRAY_RC_EN
    input  logic [31*LANES-1:0]   rc_i,
`endif
    output logic                  valid_o,
    output logic                  partial_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [31*LANES-1:0]   data_o
);
    localparam logic [30:0] P = 31'h7FFFFFFF;
`ifdef M31_SBOX_ARRAY_RC_EN
    localparam int LATENCY = 16;
`else
    localparam int LATENCY = 15;
`endif

    logic rst_n;
    assign rst_n = ~rst;

    function automatic logic [30:0] canon(input logic [30:0] v);
        return (v == P) ? 31'd0 : v;
    endfunction

    logic [LATENCY-1:0] vld_sr;
    logic [LATENCY-1:0] part_sr;
    logic [TAG_W-1:0]   tag_sr [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr  <= '0;
            part_sr <= '0;
            for (int i = 0; i < LATENCY; i++) tag_sr[i] <= '0;
        end else begin
            vld_sr  <= {vld_sr[LATENCY-2:0], valid_i};
            part_sr <= {part_sr[LATENCY-2:0], partial_i};
            tag_sr[0] <= tag_i;
            for (int i = 1; i < LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
        end
    end

    assign valid_o   = vld_sr[LATENCY-1];
    assign partial_o = part_sr[LATENCY-1];
    assign tag_o     = tag_sr[LATENCY-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [30:0] x;
        logic [30:0] x2;
        logic [30:0] x4;
        logic [30:0] x5;
        // x delayed 15: tap 9 lines up with x^4, tap 14 with x^5
        logic [30:0] dly [15];

`ifdef M31_SBOX_ARRAY_RC_EN
        logic [31:0] sum;
        logic [30:0] x_q;

        // Both operands < p, so one conditional subtract suffices
        always_comb begin
            sum = {1'b0, canon(data_i[31*k +: 31])}
                + {1'b0, canon(rc_i[31*k +: 31])};
            if (sum >= {1'b0, P}) sum = sum - {1'b0, P};
        end

        always_ff @(posedge clk) begin
            if (rst) x_q <= '0;
            else     x_q <= sum[30:0];
        end

        assign x = x_q;
`else
        assign x = canon(data_i[31*k +: 31]);
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 15; i++) dly[i] <= '0;
            end else begin
                dly[0] <= x;
                for (int i = 1; i < 15; i++) dly[i] <= dly[i-1];
            end
        end

        m31_sqr u_sq1 (.clk(clk), .rst_n(rst_n), .x(x),  .y(x2));
        m31_sqr u_sq2 (.clk(clk), .rst_n(rst_n), .x(x2), .y(x4));
        m31_mul u_mul (.clk(clk), .rst_n(rst_n), .a(x4), .b(dly[9]), .y(x5));

        // Lane 0 is always raised; other lanes bypass on partial rounds
        if (k == 0) begin : g_l0
            assign data_o[31*k +: 31] = x5;
        end else begin : g_ln
            assign data_o[31*k +: 31] = partial_o ? dly[14] : x5;
        end
    end
endmodule

// File: tb/tb_m31_sbox_array.sv
// tb_m31_sbox_array: directed-vector bench for m31_sbox_array (LANES=4)
// with a queue-based reference model checked every cycle.

module tb_m31_sbox_array;
    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int DW    = 31 * LANES;
    localparam longint unsigned P = 64'h7FFFFFFF;
`ifdef M31_SBOX_ARRAY_RC_EN
    localparam int LAT_EXP = 16;
`else
    localparam int LAT_EXP = 15;
`endif

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic             partial_i;
    logic [TAG_W-1:0] tag_i;
    logic [DW-1:0]    data_i;
    logic [DW-1:0]    rc;
    logic             valid_o;
    logic             partial_o;
    logic [TAG_W-1:0] tag_o;
    logic [DW-1:0]    data_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 0;
    int t0;

    m31_sbox_array #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .partial_i (partial_i),
        .tag_i     (tag_i),
        .data_i    (data_i),
`ifdef M31_SBOX_ARRAY_RC_EN
        .rc_i      (rc),
`endif
        .valid_o   (valid_o),
        .partial_o (partial_o),
        .tag_o     (tag_o),
        .data_o    (data_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int               due;
        logic             part;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    data;
    } exp_t;

    exp_t q[$];

    function automatic longint unsigned cn(input longint unsigned v);
        return (v == P) ? 0 : v;
    endfunction

    function automatic longint unsigned pow5(input longint unsigned x);
        longint unsigned r;
        r = (x * x) % P;
        r = (r * r) % P;
        return (r * x) % P;
    endfunction

    function automatic longint unsigned xval(input longint unsigned d,
                                             input longint unsigned r);
`ifdef M31_SBOX_ARRAY_RC_EN
        return (cn(d) + cn(r)) % P;
`else
        return cn(d) + 0 * r;
`endif
    endfunction

    function automatic logic [DW-1:0] pack4(input logic [30:0] l0,
                                            input logic [30:0] l1,
                                            input logic [30:0] l2,
                                            input logic [30:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: each accepted beat becomes an expected output due
    // LATENCY cycles later; reset discards everything queued.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                q.delete();
            end else if (valid_i) begin
                exp_t e;
                e.due  = cyc + LAT_EXP - 1;
                e.part = partial_i;
                e.tag  = tag_i;
                for (int k = 0; k < LANES; k++) begin
                    longint unsigned x;
                    x = xval(64'(data_i[31*k +: 31]), 64'(rc[31*k +: 31]));
                    if (partial_i && k > 0) e.data[31*k +: 31] = 31'(x);
                    else e.data[31*k +: 31] = 31'(pow5(x));
                end
                q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("model valid", 128'(valid_o), 128'(1));
                    chk("model partial", 128'(partial_o), 128'(q[0].part));
                    chk("model tag", 128'(tag_o), 128'(q[0].tag));
                    chk("model data", 128'(data_o), 128'(q[0].data));
                    void'(q.pop_front());
                end else begin
                    chk("model idle", 128'(valid_o), 128'(0));
                end
            end
        end
    end

    task automatic send(input logic p, input logic [TAG_W-1:0] t,
                        input logic [DW-1:0] d, input logic [DW-1:0] r);
        valid_i   = 1;
        partial_i = p;
        tag_i     = t;
        data_i    = d;
        rc        = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_i = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " arrival"}, 128'(valid_o), 128'(1));
    endtask

    initial begin
        rst = 1;
        valid_i = 0;
        partial_i = 0;
        tag_i = 0;
        data_i = 0;
        rc = 0;
        repeat (3) @(negedge clk);
        chk("reset valid", 128'(valid_o), 128'(0));
        chk("reset partial", 128'(partial_o), 128'(0));
        chk("reset tag", 128'(tag_o), 128'(0));
        chk("reset data", 128'(data_o), 128'(0));
        rst = 0;
        chk_en = 1;
        idle(2);

        send(0, 8'h5A, pack4(2, 3, 0, 31'h7FFFFFFE), '0);
        t0 = cyc;
        valid_i = 0;
        wait_valid("t1");
        chk("t1 data", 128'(data_o),
            128'(pack4(32, 243, 0, 31'h7FFFFFFE)));
        chk("t1 tag", 128'(tag_o), 128'(8'h5A));
        chk("t1 latency", 128'(cyc - t0), 128'(LAT_EXP - 1));
        @(negedge clk);
        chk("t1 single", 128'(valid_o), 128'(0));

        send(0, 8'h11, pack4(31'h7FFFFFFF, 31'h00010000, 1, 0), '0);
        valid_i = 0;
        wait_valid("t2");
        chk("t2 data", 128'(data_o), 128'(pack4(0, 31'h00040000, 1, 0)));

        send(1, 8'h21, pack4(2, 3, 4, 31'h7FFFFFFF), '0);
        send(0, 8'h22, pack4(2, 3, 4, 31'h7FFFFFFF), '0);
        valid_i = 0;
        wait_valid("t3");
        chk("t3 partial data", 128'(data_o), 128'(pack4(32, 3, 4, 0)));
        chk("t3 partial flag", 128'(partial_o), 128'(1));
        @(negedge clk);
        chk("t3 full valid", 128'(valid_o), 128'(1));
        chk("t3 full data", 128'(data_o), 128'(pack4(32, 243, 1024, 0)));
        chk("t3 full flag", 128'(partial_o), 128'(0));

        for (int i = 0; i < 20; i++) begin
            send(0, 8'(i), pack4(31'(i + 1), 31'(i * 7), 31'h7FFFFFFF,
                                 31'd12345), '0);
            if (i == 9) idle(3);
        end
        idle(LAT_EXP + 4);

        for (int i = 0; i < 8; i++)
            send(i[0], 8'(8'h40 + i), pack4(31'(i + 9), 5, 6, 7), '0);
        rst = 1;
        send(0, 8'hEE, pack4(9, 9, 9, 9), '0);
        send(0, 8'hEF, pack4(9, 9, 9, 9), '0);
        rst = 0;
        idle(2);
        send(0, 8'h77, pack4(5, 0, 0, 0), '0);
        t0 = cyc;
        valid_i = 0;
        wait_valid("t5");
        chk("t5 tag", 128'(tag_o), 128'(8'h77));
        chk("t5 data", 128'(data_o), 128'(pack4(3125, 0, 0, 0)));
        chk("t5 latency", 128'(cyc - t0), 128'(LAT_EXP - 1));
        idle(4);

`ifdef M31_SBOX_ARRAY_RC_EN
        send(0, 8'h91, pack4(3, 31'h7FFFFFFF, 0, 0),
             pack4(31'h7FFFFFFE, 5, 0, 0));
        t0 = cyc;
        valid_i = 0;
        wait_valid("rc");
        chk("rc data", 128'(data_o), 128'(pack4(32, 3125, 0, 0)));
        chk("rc latency", 128'(cyc - t0), 128'(15));
`endif

        idle(LAT_EXP + 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/m31_sbox_array.md
# m31_sbox_array

Multi-lane, fully pipelined M31 S-box (x^5 mod p, p = 2^31 − 1) for the Poseidon2 permutation datapath. One state vector of LANES field elements per beat, with a per-beat partial-round flag (only lane 0 goes through x^5; the other lanes pass through delay-matched) and a sideband tag. It sits between the round-constant/state register stage and the linear layer. It is built from the existing m31_sqr and m31_mul cores, 5 cycles each.

## Interface
- LANES, default 16: state width in field elements, minimum 1.
- TAG_W, default 8: sideband tag width, minimum 1.
- LATENCY (localparam, derived): 15, or 16 when M31_SBOX_ARRAY_RC_EN is defined.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  beat present this cycle. There is no backpressure.
- partial_i  in  1  1 = partial round, 0 = full round.
- tag_i  in  TAG_W  opaque sideband, returned unchanged.
- data_i  in  31*LANES  lane k occupies bits [31k+30:31k].
- rc_i  in  31*LANES  round constants, same packing. Present only with M31_SBOX_ARRAY_RC_EN.
- valid_o  out  1  result beat present.
- partial_o  out  1  delayed partial_i.
- tag_o  out  TAG_W  delayed tag_i.
- data_o  out  31*LANES  results, same packing.

## Operation
- Canonicalise every input lane before the S-box: the value 0x7FFFFFFF (= p) becomes 0. Values 0..p−1 pass unchanged.
- With RC enabled, per lane: x = (data + rc) mod p, computed with a 32-bit sum and one conditional subtract of p. Both operands are canonicalised first, and the sum is registered (1 extra stage).
- Per lane: x^2 via m31_sqr, then x^4 via m31_sqr. A 10-stage delay of x feeds m31_mul, which produces x^5. Lanes are independent.
- Full round (partial = 0): data_o[k] = x_k^5 for every lane.
- Partial round (partial = 1):
  - data_o[0] = x_0^5.
  - data_o[k] for k ≥ 1 = x_k, the canonical value after RC add if enabled, delayed by LATENCY.
- Lane muxing uses the partial flag delayed alongside the data. All lanes may compute x^5 every cycle.
- valid, partial and tag travel down a LATENCY-deep shift register. data_o is meaningful only when valid_o = 1.
- Submodules get rst_n = ~rst.

## Timing
- Throughput: one beat per cycle, unconditionally, with no stalls.
- Latency: a beat sampled with valid_i = 1 at edge t appears with valid_o = 1 in the cycle after edge t+LATENCY−1, i.e. exactly LATENCY cycles later.
- Gaps and beat order are preserved exactly. Bubbles give valid_o = 0.
- Mixed partial/full beats back-to-back are legal; each beat uses its own flag.
- Reset values: valid_o = 0, partial_o = 0, tag_o = 0, data_o = 0.
- rst during operation drops every in-flight beat.
  - valid_o stays 0 from the cycle after the rst edge until the first beat accepted after rst deasserts has traversed.
  - Beats presented while rst = 1 are ignored.
- No state machine. The only state is pipeline registers and the valid/flag/tag shift register.

## Configuration
- M31_SBOX_ARRAY_RC_EN defined:
  - rc_i port exists.
  - A modular-add register stage precedes the S-box.
  - LATENCY = 16.
- M31_SBOX_ARRAY_RC_EN undefined:
  - No rc_i port, no adder.
  - x = canonical data_i.
  - LATENCY = 15.

## Test plan
- Full round, LANES = 4, lanes {2, 3, 0, 0x7FFFFFFE}, tag 0x5A → after LATENCY cycles: {32, 243, 0, 0x7FFFFFFE}, tag_o = 0x5A, valid_o high for exactly one cycle.
- Boundary lanes {0x7FFFFFFF, 0x00010000, 1, 0} → {0, 0x00040000, 1, 0}.
  - 2^80 mod p = 2^18.
- Partial round, lanes {2, 3, 4, 0x7FFFFFFF} → {32, 3, 4, 0}, partial_o = 1. Follow with the same data as a full round on the next cycle → {32, 243, 1024, 0}.
- Stream of 20 back-to-back beats (tags 0..19, lane 0 = tag+1) with a 3-cycle bubble after beat 9 → same tags, in order, with an identical gap; lane 0 = (tag+1)^5 mod p.
- Assert rst for 2 cycles while 8 beats are in flight → valid_o = 0 until the first post-reset beat emerges LATENCY cycles after acceptance. No stale beat appears.
- RC build: data 3, rc 0x7FFFFFFE → 32. Data 0x7FFFFFFF, rc 5 → 3125. LATENCY = 16 is checked.
